// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction memory request/ack channel plus the IF/ID
// register and branch-redirect inputs exchanged with decode.
interface instr_fetch_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 6;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            pcsrc;
  logic [XLEN-1:0] branch_offset;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic [FW-1:0]   opcode;
  logic [FW-1:0]   funct;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, opcode, funct,
    input  imem_ack, imem_rdata, stall, pcsrc, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, opcode, funct,
    output imem_ack, imem_rdata, stall, pcsrc, branch_offset
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack memory reads, IF/ID register with a
// one-entry skid buffer, and branch redirects resolved in decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] addr_q;
  logic            req_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            valid_q;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic            consume;
  logic            redirect;
  logic            slot_free;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  assign consume   = valid_q & ~bus.stall;
  assign redirect  = consume & bus.pcsrc;
  assign slot_free = ~valid_q | consume;
  assign target    = instr_pc_q + (bus.branch_offset << 2);
  assign pc_inc    = pc + XLEN'(4);

  // addr_q tracks pc except while draining, where it must keep the
  // abandoned address stable until the memory acknowledges it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        FETCH: begin
          if (redirect) begin
            valid_q <= 1'b0;
            pc      <= target;
            if (bus.imem_ack) begin
              addr_q <= target;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            pc     <= pc_inc;
            addr_q <= pc_inc;
            if (slot_free) begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= pc_inc;
              valid_q    <= 1'b1;
            end else begin
              skid_instr <= bus.imem_rdata;
              skid_pc    <= pc_inc;
              state      <= FULL;
              req_q      <= 1'b0;
            end
          end else if (consume) begin
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (redirect) begin
            pc      <= target;
            addr_q  <= target;
            valid_q <= 1'b0;
            state   <= FETCH;
            req_q   <= 1'b1;
          end else if (consume) begin
            instr_q    <= skid_instr;
            instr_pc_q <= skid_pc;
            state      <= FETCH;
            req_q      <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) begin
            addr_q <= pc;
            state  <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall/skid, branch
// redirect with zero and two-cycle memory latency, async reset, PC wrap.
module tb_instr_fetch_unit;
  logic clk;
  logic rst;
  int   lat;
  int   wait_cnt;
  int   n_tests;
  int   n_fail;
  logic found;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)                      return 32'h0000_0020;
    else if (a == 32'h4)                 return 32'h8C01_0004;
    else if (a == 32'h10 || a == 32'h14) return 32'h1022_0003;
    else                                 return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks after lat wait cycles on a stable request.
  always_comb begin
    bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
    bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    wait_cnt = 0;
    rst = 1'b1;
    lat = 0;
    bus.stall = 1'b0;
    bus.pcsrc = 1'b0;
    bus.branch_offset = 32'h0;
    #2;
    chk("rst_req",    32'(bus.imem_req), 32'h0);
    chk("rst_addr",   bus.imem_addr, 32'h0);
    chk("rst_instr",  bus.instr, 32'h0);
    chk("rst_ipc",    bus.instr_pc, 32'h0);
    chk("rst_valid",  32'(bus.instr_valid), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Zero-latency sequential fetch
    tick();
    chk("first_req",  32'(bus.imem_req), 32'h1);
    chk("first_addr", bus.imem_addr, 32'h0);
    tick();
    chk("seq0_ipc",   bus.instr_pc, 32'h4);
    chk("seq0_op",    32'(bus.opcode), 32'h00);
    chk("seq0_fn",    32'(bus.funct), 32'h20);
    chk("seq0_addr",  bus.imem_addr, 32'h4);
    tick();
    chk("seq1_instr", bus.instr, 32'h8C01_0004);
    chk("seq1_ipc",   bus.instr_pc, 32'h8);
    chk("seq1_addr",  bus.imem_addr, 32'h8);
    tick();
    chk("seq2_ipc",   bus.instr_pc, 32'hC);
    chk("seq2_addr",  bus.imem_addr, 32'hC);

    // Stall three cycles: second word parks in skid, fetching pauses
    bus.stall = 1'b1;
    tick();
    chk("full_req",   32'(bus.imem_req), 32'h0);
    chk("full_ipc",   bus.instr_pc, 32'hC);
    bus.pcsrc = 1'b1;
    bus.branch_offset = 32'h40;
    tick();
    chk("full_req2",  32'(bus.imem_req), 32'h0);
    chk("full_valid", 32'(bus.instr_valid), 32'h1);
    tick();
    chk("full_ipc3",  bus.instr_pc, 32'hC);
    chk("full_ins3",  bus.instr, mem_word(32'h8));
    bus.stall = 1'b0;
    bus.pcsrc = 1'b0;
    tick();
    chk("skid_instr", bus.instr, mem_word(32'hC));
    chk("skid_ipc",   bus.instr_pc, 32'h10);
    chk("resume_req", 32'(bus.imem_req), 32'h1);
    chk("resume_addr", bus.imem_addr, 32'h10);
    tick();
    chk("br_instr",   bus.instr, 32'h1022_0003);
    chk("br_ipc",     bus.instr_pc, 32'h14);

    // Branch at 0x10, offset 3, zero latency
    bus.pcsrc = 1'b1;
    bus.branch_offset = 32'h3;
    tick();
    bus.pcsrc = 1'b0;
    chk("redir_valid", 32'(bus.instr_valid), 32'h0);
    chk("redir_addr",  bus.imem_addr, 32'h20);
    tick();
    chk("tgt_valid",  32'(bus.instr_valid), 32'h1);
    chk("tgt_ipc",    bus.instr_pc, 32'h24);
    chk("tgt_instr",  bus.instr, mem_word(32'h20));

    // Two-cycle latency, branch at 0x14 with fetch of 0x18 outstanding
    rst = 1'b1;
    lat = 2;
    tick();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (bus.instr_valid && bus.instr_pc == 32'h18) found = 1'b1;
    end
    chk("lat_find_br", 32'(found), 32'h1);
    bus.pcsrc = 1'b1;
    bus.branch_offset = 32'h3;
    tick();
    bus.pcsrc = 1'b0;
    chk("drain_valid", 32'(bus.instr_valid), 32'h0);
    chk("drain_addr",  bus.imem_addr, 32'h18);
    chk("drain_req",   32'(bus.imem_req), 32'h1);
    tick();
    chk("drain_addr2", bus.imem_addr, 32'h18);
    tick();
    chk("post_drain_addr",  bus.imem_addr, 32'h24);
    chk("post_drain_valid", 32'(bus.instr_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.instr_valid) found = 1'b1;
    end
    chk("lat_tgt_seen", 32'(found), 32'h1);
    chk("lat_tgt_ipc",  bus.instr_pc, 32'h28);
    chk("lat_tgt_ins",  bus.instr, mem_word(32'h24));

    // Async reset with a request outstanding
    lat = 100;
    tick();
    chk("pend_req",  32'(bus.imem_req), 32'h1);
    chk("pend_addr", bus.imem_addr, 32'h28);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_req",   32'(bus.imem_req), 32'h0);
    chk("arst_addr",  bus.imem_addr, 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    chk("arst_ipc",   bus.instr_pc, 32'h0);
    chk("arst_valid", 32'(bus.instr_valid), 32'h0);
    chk("arst_opfn",  {20'h0, bus.opcode, bus.funct}, 32'h0);
    tick();
    rst = 1'b0;
    lat = 0;
    tick();
    chk("restart_req",  32'(bus.imem_req), 32'h1);
    chk("restart_addr", bus.imem_addr, 32'h0);
    tick();
    chk("restart_ipc",  bus.instr_pc, 32'h4);
    chk("restart_ins",  bus.instr, 32'h0000_0020);

    // Redirect to 0xFFFFFFFC, then PC wraps to zero
    bus.pcsrc = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFE;
    tick();
    bus.pcsrc = 1'b0;
    chk("wrap_tgt_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_valid0",   32'(bus.instr_valid), 32'h0);
    tick();
    chk("wrap_addr",  bus.imem_addr, 32'h0);
    chk("wrap_ipc",   bus.instr_pc, 32'h0);
    chk("wrap_valid", 32'(bus.instr_valid), 32'h1);
    chk("wrap_instr", bus.instr, mem_word(32'hFFFF_FFFC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
